password_entry: RTL and testbench

//  Keypad-side entry stage feeding passwordcompare. Collects 4-bit key digits into a
//  32-bit candidate code; supports delete, clear and enter. On a valid enter it drives

---
 rtl/pw_pkg.sv | 40 ++++
 rtl/pw_idle_timer.sv | 43 ++++
 rtl/password_entry.sv | 141 ++++++++++++++
 tb/tb_password_entry.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pw_pkg.sv
// Shared definitions for the password entry/compare path: widths, FSM state
// encoding and the key-action priority decode.
package pw_pkg;

  localparam int DIGIT_W = 4;
  localparam int CODE_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_SUBMIT = 2'd2
  } pw_state_e;

  // Key priority, highest first: clear > enter > delete > digit.
  localparam int PRIO_CLEAR = 3;
  localparam int PRIO_ENTER = 2;
  localparam int PRIO_DEL   = 1;
  localparam int PRIO_DIGIT = 0;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_CLEAR = 3'd1,
    ACT_ENTER = 3'd2,
    ACT_DEL   = 3'd3,
    ACT_DIGIT = 3'd4
  } key_act_e;

  // Lower-priority strobes in the same cycle are dropped without error.
  function automatic key_act_e key_decode(input logic clear_s, input logic enter_s,
                                          input logic del_s, input logic digit_s);
    key_act_e act;
    act = ACT_NONE;
    if (clear_s)      act = ACT_CLEAR;
    else if (enter_s) act = ACT_ENTER;
    else if (del_s)   act = ACT_DEL;
    else if (digit_s) act = ACT_DIGIT;
    return act;
  endfunction

endpackage

// File: rtl/pw_idle_timer.sv
// Inactivity timer: counts while run is high, clears on restart or when not
// running, and pulses expire on the last cycle of the window.
module pw_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic clk,
  input  logic clr,
  input  logic restart,
  input  logic run,
  output logic expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, clr, restart, run};
      assign expire    = 1'b0;
    end else begin : g_on
      localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

      logic [TW-1:0] cnt_q;
      logic [TW-1:0] cnt_d;
      logic          at_end;

      assign at_end = (cnt_q == TW'(TIMEOUT_CYCLES - 1));

      always_comb begin
        cnt_d = cnt_q;
        if (restart || !run || at_end) cnt_d = '0;
        else                           cnt_d = cnt_q + TW'(1);
      end

      always_ff @(posedge clk) begin
        if (!clr) cnt_q <= '0;
        else      cnt_q <= cnt_d;
      end

      // A key strobe on the expiry cycle restarts the window instead.
      assign expire = run && !restart && at_end;
    end
  endgenerate

endmodule

// File: rtl/password_entry.sv
// Keypad entry stage: shifts digits into a candidate code, handles delete/clear/
// enter, presents code+start to the comparator, and discards idle entries.
module password_entry
  import pw_pkg::*;
#(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned START_HOLD     = 1,
  parameter int unsigned REQUIRE_FULL   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        key_valid,
  input  logic [DIGIT_W-1:0]          key_code,
  input  logic                        key_del,
  input  logic                        key_clear,
  input  logic                        key_enter,
  output logic [DIGIT_W*DIGITS-1:0]   code,
  output logic                        start,
  output logic [3:0]                  digit_cnt,
  output logic                        busy,
  output logic                        entry_err,
  output logic                        timeout,
  output pw_state_e                   state_dbg
);

  localparam int CW = DIGIT_W * DIGITS;
  localparam int HW = $clog2(START_HOLD + 1);

  pw_state_e         state_q;
  logic [CW-1:0]     code_q;
  logic [3:0]        cnt_q;
  logic              start_q;
  logic              busy_q;
  logic              err_q;
  logic              tmo_q;
  logic [HW-1:0]     hold_q;

  key_act_e          act;
  logic              any_key;
  logic              enter_ok;
  logic              expire;

  assign act      = key_decode(key_clear, key_enter, key_del, key_valid);
  assign any_key  = (act != ACT_NONE);
  assign enter_ok = (cnt_q != 4'd0) &&
                    ((REQUIRE_FULL == 0) || (cnt_q == 4'(DIGITS)));

  pw_idle_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .clr     (clr),
    .restart (any_key && (state_q != ST_SUBMIT)),
    .run     (state_q == ST_ENTRY),
    .expire  (expire)
  );

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      err_q <= 1'b0;
      tmo_q <= 1'b0;
      case (state_q)
        ST_SUBMIT: begin
          // Code stays frozen while start is high; wipe on the falling edge.
          if (hold_q == HW'(START_HOLD - 1)) begin
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            code_q  <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            state_q <= ST_IDLE;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        default: begin
          case (act)
            ACT_CLEAR: begin
              code_q  <= '0;
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end
            ACT_ENTER: begin
              if (enter_ok) begin
                state_q <= ST_SUBMIT;
                start_q <= 1'b1;
                busy_q  <= 1'b1;
                hold_q  <= '0;
              end else begin
                err_q <= 1'b1;
              end
            end
            ACT_DEL: begin
              if (cnt_q != 4'd0) begin
                code_q  <= {{DIGIT_W{1'b0}}, code_q[CW-1:DIGIT_W]};
                cnt_q   <= cnt_q - 4'd1;
                state_q <= (cnt_q == 4'd1) ? ST_IDLE : ST_ENTRY;
              end
            end
            ACT_DIGIT: begin
              if (cnt_q < 4'(DIGITS)) begin
                code_q  <= {code_q[CW-DIGIT_W-1:0], key_code};
                cnt_q   <= cnt_q + 4'd1;
                state_q <= ST_ENTRY;
              end else begin
                err_q <= 1'b1;
              end
            end
            default: begin
              if (expire) begin
                code_q  <= '0;
                cnt_q   <= '0;
                state_q <= ST_IDLE;
                tmo_q   <= 1'b1;
              end
            end
          endcase
        end
      endcase
    end
  end

  assign code      = code_q;
  assign start     = start_q;
  assign digit_cnt = cnt_q;
  assign busy      = busy_q;
  assign entry_err = err_q;
  assign timeout   = tmo_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_password_entry.sv
// Self-checking bench for password_entry: scenario tasks plus a start/code
// monitor fed by an expected-code queue.
module tb_password_entry;
  import pw_pkg::*;

  localparam int SH = 3;
  localparam int TO = 16;
  localparam logic [31:0] PW = 32'h12345678;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_del = 1'b0;
  logic        key_clear = 1'b0;
  logic        key_enter = 1'b0;
  logic [31:0] code;
  logic        start;
  logic [3:0]  digit_cnt;
  logic        busy;
  logic        entry_err;
  logic        timeout;
  pw_state_e   state_dbg;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  // clock/reset
  always #5 clk = ~clk;

  password_entry #(
    .DIGITS         (8),
    .START_HOLD     (SH),
    .REQUIRE_FULL   (1),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_del   (key_del),
    .key_clear (key_clear),
    .key_enter (key_enter),
    .code      (code),
    .start     (start),
    .digit_cnt (digit_cnt),
    .busy      (busy),
    .entry_err (entry_err),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  // downstream comparator model: samples code on each start-high edge
  logic cmp_out;
  always @(posedge clk) begin
    if (!clr)      cmp_out <= 1'b0;
    else if (start) cmp_out <= (code == PW);
  end

  // scoreboard monitor: each start run pops one expected code
  bit          in_run = 0;
  bit          abort_run = 0;
  int          run_len = 0;
  logic [31:0] cur_exp = '0;
  always @(negedge clk) begin
    if (start === 1'b1) begin
      if (!in_run) begin
        in_run = 1;
        run_len = 0;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_start: got start=1 with no queued code=%h", code);
          cur_exp = code;
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      run_len++;
      total++;
      if (code !== cur_exp || busy !== 1'b1) begin
        bad++;
        $display("FAIL sb_code: got code=%h busy=%b want code=%h busy=1", code, busy, cur_exp);
      end
    end else if (in_run) begin
      in_run = 0;
      if (!abort_run) begin
        total++;
        if (run_len != SH) begin
          bad++;
          $display("FAIL sb_hold_len: got %0d want %0d", run_len, SH);
        end
      end
      abort_run = 0;
    end
  end

  // driver tasks: called at a negedge, strobes sampled at the next posedge
  task automatic drive(input logic v, input logic [3:0] c, input logic d,
                       input logic cl, input logic e);
    key_valid = v; key_code = c; key_del = d; key_clear = cl; key_enter = e;
    @(posedge clk); #1;
    key_valid = 0; key_del = 0; key_clear = 0; key_enter = 0;
    @(negedge clk);
  endtask

  task automatic fill(output logic [31:0] m);
    logic [3:0] dg;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      dg = 4'($urandom_range(0, 15));
      drive(1, dg, 0, 0, 0);
      m = {m[27:0], dg};
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr = 0;
    key_valid = 1; key_code = 4'hF; key_del = 1; key_clear = 1; key_enter = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (code !== 32'h0 || digit_cnt !== 4'd0 || start !== 1'b0 || busy !== 1'b0 ||
        entry_err !== 1'b0 || timeout !== 1'b0 || state_dbg !== ST_IDLE) begin
      bad++;
      $display("FAIL reset: got code=%h cnt=%0d start=%b busy=%b err=%b tmo=%b st=%0d want all zero",
               code, digit_cnt, start, busy, entry_err, timeout, state_dbg);
    end
    key_valid = 0; key_del = 0; key_clear = 0; key_enter = 0;
    clr = 1;
    @(negedge clk);
  endtask

  task automatic test_full_submit();
    logic [31:0] m;
    m = '0;
    total++;
    if (cmp_out !== 1'b0) begin bad++; $display("FAIL cmp_before: got %b want 0", cmp_out); end
    for (int d = 1; d <= 8; d++) begin
      drive(1, 4'(d), 0, 0, 0);
      m = {m[27:0], 4'(d)};
      total++;
      if (digit_cnt !== 4'(d)) begin bad++; $display("FAIL digit_cnt: got %0d want %0d", digit_cnt, d); end
    end
    total++;
    if (code !== 32'h12345678 || code !== m) begin
      bad++; $display("FAIL full_code: got %h want %h", code, 32'h12345678);
    end
    exp_q.push_back(32'h12345678);
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < SH; i++) begin
      total++;
      if (start !== 1'b1 || state_dbg !== ST_SUBMIT) begin
        bad++; $display("FAIL start_high: cycle %0d got start=%b st=%0d want 1/SUBMIT", i, start, state_dbg);
      end
      @(negedge clk);
    end
    total++;
    if (start !== 1'b0 || code !== 32'h0 || digit_cnt !== 4'd0 || busy !== 1'b0 || state_dbg !== ST_IDLE) begin
      bad++; $display("FAIL post_submit: got start=%b code=%h cnt=%0d busy=%b want 0/0/0/0",
                      start, code, digit_cnt, busy);
    end
    total++;
    if (cmp_out !== 1'b1) begin bad++; $display("FAIL cmp_after: got %b want 1", cmp_out); end
  endtask

  task automatic test_delete_short();
    logic [31:0] m;
    logic [3:0]  dg;
    drive(1, 4'd1, 0, 0, 0);
    drive(1, 4'd2, 0, 0, 0);
    drive(1, 4'd3, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(1, 4'd9, 0, 0, 0);
    total++;
    if (code !== 32'h00000129 || digit_cnt !== 4'd3) begin
      bad++; $display("FAIL del_code: got code=%h cnt=%0d want 00000129/3", code, digit_cnt);
    end
    drive(0, 0, 0, 0, 1);
    total++;
    if (entry_err !== 1'b1 || start !== 1'b0 || busy !== 1'b0 || code !== 32'h00000129) begin
      bad++; $display("FAIL short_enter: got err=%b start=%b busy=%b code=%h want 1/0/0/00000129",
                      entry_err, start, busy, code);
    end
    @(negedge clk);
    total++;
    if (entry_err !== 1'b0 || start !== 1'b0) begin
      bad++; $display("FAIL err_pulse: got err=%b start=%b want 0/0", entry_err, start);
    end
    drive(0, 0, 0, 1, 0);
    fill(m);
    dg = 4'($urandom_range(0, 15));
    drive(1, dg, 0, 0, 0);
    total++;
    if (entry_err !== 1'b1 || code !== m || digit_cnt !== 4'd8) begin
      bad++; $display("FAIL ninth_digit: got err=%b code=%h cnt=%0d want 1/%h/8", entry_err, code, digit_cnt, m);
    end
    drive(0, 0, 0, 1, 0);
    total++;
    if (code !== 32'h0 || digit_cnt !== 4'd0 || entry_err !== 1'b0 || state_dbg !== ST_IDLE) begin
      bad++; $display("FAIL clear: got code=%h cnt=%0d err=%b want 0/0/0", code, digit_cnt, entry_err);
    end
  endtask

  task automatic test_priority();
    logic [31:0] m;
    int n;
    fill(m);
    drive(1, 4'h5, 0, 1, 1);
    total++;
    if (code !== 32'h0 || digit_cnt !== 4'd0 || entry_err !== 1'b0 || start !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL prio_clear: got code=%h cnt=%0d err=%b start=%b want 0/0/0/0",
                      code, digit_cnt, entry_err, start);
    end
    drive(1, 4'h3, 0, 0, 0);
    drive(1, 4'h4, 0, 0, 0);
    drive(1, 4'h7, 1, 0, 0);
    total++;
    if (code !== 32'h00000003 || digit_cnt !== 4'd1 || entry_err !== 1'b0) begin
      bad++; $display("FAIL prio_del: got code=%h cnt=%0d err=%b want 00000003/1/0", code, digit_cnt, entry_err);
    end
    m = 32'h3;
    for (int i = 0; i < 7; i++) begin
      drive(1, 4'(i + 8), 0, 0, 0);
      m = {m[27:0], 4'(i + 8)};
    end
    exp_q.push_back(m);
    drive(1, 4'h2, 1, 0, 1);
    total++;
    if (start !== 1'b1 || code !== m || digit_cnt !== 4'd8) begin
      bad++; $display("FAIL prio_enter: got start=%b code=%h cnt=%0d want 1/%h/8", start, code, digit_cnt, m);
    end
    drive(1, 4'h1, 0, 0, 0);
    total++;
    if (entry_err !== 1'b0 || digit_cnt !== 4'd8 || busy !== 1'b1) begin
      bad++; $display("FAIL busy_digit: got err=%b cnt=%0d busy=%b want 0/8/1", entry_err, digit_cnt, busy);
    end
    drive(0, 0, 0, 1, 0);
    total++;
    if (entry_err !== 1'b0 || digit_cnt !== 4'd8 || code !== m) begin
      bad++; $display("FAIL busy_clear: got err=%b cnt=%0d code=%h want 0/8/%h", entry_err, digit_cnt, code, m);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy !== 1'b0 || code !== 32'h0 || digit_cnt !== 4'd0) begin
      bad++; $display("FAIL busy_release: got busy=%b code=%h cnt=%0d want 0/0/0", busy, code, digit_cnt);
    end
  endtask

  task automatic test_timeout();
    bit early;
    early = 0;
    drive(1, 4'hA, 0, 0, 0);
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      if (timeout !== 1'b0) early = 1;
    end
    total++;
    if (early) begin bad++; $display("FAIL tmo_early: got early pulse want none before %0d", TO); end
    @(negedge clk);
    total++;
    if (timeout !== 1'b1 || code !== 32'h0 || digit_cnt !== 4'd0 || state_dbg !== ST_IDLE) begin
      bad++; $display("FAIL tmo_fire: got tmo=%b code=%h cnt=%0d want 1/0/0", timeout, code, digit_cnt);
    end
    @(negedge clk);
    total++;
    if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_pulse: got %b want 0", timeout); end
    drive(1, 4'hA, 0, 0, 0);
    repeat (TO - 1) @(negedge clk);
    drive(1, 4'hB, 0, 0, 0);
    total++;
    if (timeout !== 1'b0 || digit_cnt !== 4'd2 || code !== 32'h000000AB) begin
      bad++; $display("FAIL tmo_key_wins: got tmo=%b cnt=%0d code=%h want 0/2/000000AB", timeout, digit_cnt, code);
    end
    early = 0;
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      if (timeout !== 1'b0) early = 1;
    end
    total++;
    if (early || digit_cnt !== 4'd2) begin
      bad++; $display("FAIL tmo_restart: got early=%b cnt=%0d want 0/2", early, digit_cnt);
    end
    drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid_submit();
    logic [31:0] m;
    fill(m);
    exp_q.push_back(m);
    drive(0, 0, 0, 0, 1);
    total++;
    if (start !== 1'b1) begin bad++; $display("FAIL mid_start: got %b want 1", start); end
    @(negedge clk);
    abort_run = 1;
    clr = 0;
    @(posedge clk); #1;
    clr = 1;
    @(negedge clk);
    total++;
    if (start !== 1'b0 || busy !== 1'b0 || code !== 32'h0 || digit_cnt !== 4'd0 || state_dbg !== ST_IDLE) begin
      bad++; $display("FAIL mid_reset: got start=%b busy=%b code=%h cnt=%0d want 0/0/0/0",
                      start, busy, code, digit_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_submit();
    test_delete_short();
    test_priority();
    test_timeout();
    test_reset_mid_submit();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d queued codes want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
